// File: rtl/wb_regbank_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_regbank_pkg : slot modes, FSM encoding and helpers for wb_regbank_gen
// Rev 1.0
// ---------------------------------------------------------------------------
package wb_regbank_pkg;

  localparam logic [1:0] MODE_STORAGE = 2'd0;
  localparam logic [1:0] MODE_WIRE    = 2'd1;
  localparam logic [1:0] MODE_EXT     = 2'd2;
  localparam logic [1:0] MODE_RO      = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int slot_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_regbank_slot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_regbank_slot : one register slot (storage / wire / ext-ack / read-only)
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_regbank_slot
  import wb_regbank_pkg::*;
#(
  parameter int               DATA_W  = 32,
  parameter logic [1:0]       MODE    = MODE_STORAGE,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                acc_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [DATA_W-1:0]   dat_i,
  output logic [DATA_W-1:0]   reg_o,
  output logic                reg_wr_o,
  output logic                reg_rd_o
);

  localparam logic [DATA_W-1:0] INIT_VAL = (MODE == MODE_STORAGE) ? RST_VAL : '0;

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] wmask;
  logic              w_wr;

  assign w_wr     = acc_i && we_i && (MODE != MODE_RO);
  assign reg_rd_o = acc_i && !we_i;

  // Only storage slots honour byte selects; latched slots take the whole word.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      wmask[b*8 +: 8] = (MODE == MODE_STORAGE) ? {8{sel_i[b]}} : 8'hFF;
    end
    data_d = w_wr ? ((data_q & ~wmask) | (dat_i & wmask)) : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= INIT_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  if (MODE == MODE_STORAGE) begin : g_storage
    logic wr_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_q <= 1'b0;
      end else begin
        wr_q <= w_wr;
      end
    end
    assign reg_o    = data_q;
    assign reg_wr_o = wr_q;
  end else if (MODE == MODE_RO) begin : g_readonly
    assign reg_o    = data_q;
    assign reg_wr_o = 1'b0;
  end else begin : g_latch
    // Write data is visible during the access cycle and held afterwards.
    assign reg_o    = data_d;
    assign reg_wr_o = w_wr;
  end

endmodule
`default_nettype wire

// File: rtl/wb_regbank_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_regbank_gen : parametrised Wishbone register bank with per-slot modes
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_regbank_gen
  import wb_regbank_pkg::*;
#(
  parameter int                      NREGS        = 4,
  parameter int                      ADR_W        = 2,
  parameter int                      DATA_W       = 32,
  parameter logic [2*NREGS-1:0]      MODES        = '0,
  parameter logic [NREGS*DATA_W-1:0] RST_VAL      = '0,
  parameter int                      ACK_TIMEOUT  = 15,
  parameter int                      UNMAPPED_ERR = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [ADR_W+1:2]          wb_adr_i,
  input  logic [DATA_W/8-1:0]       wb_sel_i,
  input  logic [DATA_W-1:0]         wb_dat_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  output logic                      wb_stall_o,
  output logic [DATA_W-1:0]         wb_dat_o,
  output logic [NREGS*DATA_W-1:0]   reg_o,
  input  logic [NREGS*DATA_W-1:0]   reg_i,
  output logic [NREGS-1:0]          reg_wr_o,
  output logic [NREGS-1:0]          reg_rd_o,
  input  logic [NREGS-1:0]          reg_wack_i,
  input  logic [NREGS-1:0]          reg_rack_i
);

  localparam int               SEL_W   = DATA_W/8;
  localparam int               CNT_W   = clog2(ACK_TIMEOUT + 1);
  localparam logic [ADR_W:0]   NREGS_L = (ADR_W+1)'(NREGS);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(ACK_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic [ADR_W-1:0]    adr_q;
  logic                we_q;
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   dat_q;

  logic                w_accept;
  logic                w_mapped;
  logic                w_ext;
  logic                w_resp;
  logic [DATA_W-1:0]   w_rdata;

  assign w_accept   = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign w_mapped   = {1'b0, adr_q} < NREGS_L;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = (state_q != ST_IDLE);
  assign wb_dat_o   = rdat_q;

  // Storage slots read back their own value; all other modes read reg_i.
  always_comb begin
    w_rdata = '0;
    w_ext   = 1'b0;
    w_resp  = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      if (adr_q == ADR_W'(k)) begin
        w_rdata = (MODES[2*k +: 2] == MODE_STORAGE) ? reg_o[slot_lsb(k, DATA_W) +: DATA_W]
                                                    : reg_i[slot_lsb(k, DATA_W) +: DATA_W];
        w_ext   = (MODES[2*k +: 2] == MODE_EXT);
        w_resp  = we_q ? reg_wack_i[k] : reg_rack_i[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        if (!w_mapped) begin
          state_d = ST_DONE;
          if (UNMAPPED_ERR != 0) err_d = 1'b1;
          else                   ack_d = 1'b1;
        end else if (w_ext && !w_resp) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          rdat_d  = we_q ? '0 : w_rdata;
        end
      end
      ST_WAIT: begin
        // A response in the expiry cycle still wins over the timeout.
        if (w_resp) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          rdat_d  = we_q ? '0 : w_rdata;
        end else if (cnt_q == CNT_END) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      if (w_accept) begin
        adr_q <= wb_adr_i;
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
      end
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_slot
    logic w_acc;
    assign w_acc = (state_q == ST_ACCESS) && (adr_q == ADR_W'(k));

    wb_regbank_slot #(
      .DATA_W  (DATA_W),
      .MODE    (MODES[2*k +: 2]),
      .RST_VAL (RST_VAL[slot_lsb(k, DATA_W) +: DATA_W])
    ) u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .acc_i    (w_acc),
      .we_i     (we_q),
      .sel_i    (sel_q),
      .dat_i    (dat_q),
      .reg_o    (reg_o[slot_lsb(k, DATA_W) +: DATA_W]),
      .reg_wr_o (reg_wr_o[k]),
      .reg_rd_o (reg_rd_o[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_regbank_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_regbank_gen : directed and random checks of two wb_regbank_gen builds
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_regbank_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_a = 1'b0, stb_a = 1'b0, cyc_b = 1'b0, stb_b = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat = '0;
  logic [95:0] reg_i = '0;
  logic [2:0]  wack_a = '0, rack_a = '0, zero3 = '0;

  logic        ack_a, err_a, rty_a, stall_a, ack_b, err_b, rty_b, stall_b;
  logic [31:0] dat_a, dat_b;
  logic [95:0] reg_o_a, reg_o_b;
  logic [2:0]  wr_a, rd_a, wr_b, rd_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // A: storage / wire / ext-ack, unmapped slot acks
  wb_regbank_gen #(
    .NREGS(3), .ADR_W(2), .DATA_W(32), .MODES(6'b10_01_00),
    .RST_VAL({32'h0, 32'h0, 32'hDEADBEEF}), .ACK_TIMEOUT(15), .UNMAPPED_ERR(0)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc_a), .wb_stb_i(stb_a), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_ack_o(ack_a), .wb_err_o(err_a),
    .wb_rty_o(rty_a), .wb_stall_o(stall_a), .wb_dat_o(dat_a), .reg_o(reg_o_a), .reg_i(reg_i),
    .reg_wr_o(wr_a), .reg_rd_o(rd_a), .reg_wack_i(wack_a), .reg_rack_i(rack_a)
  );

  // B: storage / wire / read-only, unmapped slot errors
  wb_regbank_gen #(
    .NREGS(3), .ADR_W(2), .DATA_W(32), .MODES(6'b11_01_00),
    .RST_VAL({32'h0, 32'h0, 32'hDEADBEEF}), .ACK_TIMEOUT(15), .UNMAPPED_ERR(1)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc_b), .wb_stb_i(stb_b), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_ack_o(ack_b), .wb_err_o(err_b),
    .wb_rty_o(rty_b), .wb_stall_o(stall_b), .wb_dat_o(dat_b), .reg_o(reg_o_b), .reg_i(reg_i),
    .reg_wr_o(wr_b), .reg_rd_o(rd_b), .reg_wack_i(zero3), .reg_rack_i(zero3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Wishbone access; lat counts cycles from the accept cycle to the termination.
  task automatic xfer(input bit which, input bit wr, input logic [1:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int resp_at,
                      output bit ack, output bit err, output logic [31:0] rdat, output int lat,
                      output logic [2:0] wr1, output logic [2:0] rd1, output logic [2:0] wr2,
                      output logic [95:0] rego1, output bit stall_all);
    we = wr; adr = a; sel = s; dat = d;
    if (which) begin cyc_b = 1'b1; stb_b = 1'b1; end
    else       begin cyc_a = 1'b1; stb_a = 1'b1; end
    @(posedge clk); #1;
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    lat = 1;
    wack_a = (!which && wr  && lat == resp_at) ? 3'b100 : 3'b000;
    rack_a = (!which && !wr && lat == resp_at) ? 3'b100 : 3'b000;
    wr1   = which ? wr_b : wr_a;
    rd1   = which ? rd_b : rd_a;
    rego1 = which ? reg_o_b : reg_o_a;
    wr2   = '0;
    stall_all = which ? stall_b : stall_a;
    ack  = which ? ack_b : ack_a;
    err  = which ? err_b : err_a;
    while (!ack && !err && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      wack_a = (!which && wr  && lat == resp_at) ? 3'b100 : 3'b000;
      rack_a = (!which && !wr && lat == resp_at) ? 3'b100 : 3'b000;
      if (lat == 2) wr2 = which ? wr_b : wr_a;
      stall_all = stall_all & (which ? stall_b : stall_a);
      ack = which ? ack_b : ack_a;
      err = which ? err_b : err_a;
    end
    rdat = which ? dat_b : dat_a;
    wack_a = '0; rack_a = '0;
    @(posedge clk); #1;
    chk("term_one_cycle", {30'b0, (which ? ack_b : ack_a), (which ? err_b : err_a)}, 32'h0);
    chk("idle_after",     {31'b0, (which ? stall_b : stall_a)}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ack, err, seen, w;
    logic [31:0] rdat, d, mask, m_stor;
    logic [2:0]  wr1, rd1, wr2;
    logic [95:0] rego1;
    logic [3:0]  s;
    logic [1:0]  slot;
    int          lat;
    bit          stall_all;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_term",  {28'b0, ack_a, err_a, ack_b, err_b}, 32'h0);
    chk("rst_dat",   dat_a | dat_b, 32'h0);
    chk("rst_strb",  {20'b0, wr_a, rd_a, wr_b, rd_b}, 32'h0);
    chk("rst_slot0", reg_o_a[31:0], 32'hDEADBEEF);
    chk("rst_stall", {30'b0, stall_a, stall_b}, 32'h0);
    chk("rty",       {30'b0, rty_a, rty_b}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // reset during ACCESS drops the write and its ack
    we = 1'b1; adr = 2'd0; sel = 4'hF; dat = 32'h0BADF00D; cyc_a = 1'b1; stb_a = 1'b1;
    @(posedge clk); #1;
    cyc_a = 1'b0; stb_a = 1'b0;
    chk("midrst_in_access", {31'b0, stall_a}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen |= ack_a | err_a;
      @(posedge clk); #1;
    end
    chk("midrst_noterm", {31'b0, seen}, 32'h0);
    chk("midrst_slot0",  reg_o_a[31:0], 32'hDEADBEEF);

    // storage byte-select write, then readback
    xfer(0, 1, 2'd0, 4'b0101, 32'h11223344, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("st_wr_lat",  lat, 2);
    chk("st_wr_term", {30'b0, ack, err}, 32'h2);
    chk("st_wr_strb1", wr1, 3'b000);
    chk("st_wr_strb2", wr2, 3'b001);
    chk("st_wr_val",  reg_o_a[31:0], 32'hDE22BE44);
    xfer(0, 0, 2'd0, 4'hF, 32'h0, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("st_rd_lat",  lat, 2);
    chk("st_rd_dat",  rdat, 32'hDE22BE44);
    chk("st_rd_strb", rd1, 3'b001);

    // wire slot
    xfer(0, 1, 2'd1, 4'hF, 32'hA5A5A5A5, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("wire_wr_lat",  lat, 2);
    chk("wire_reg_t1",  rego1[63:32], 32'hA5A5A5A5);
    chk("wire_strb_t1", wr1, 3'b010);
    chk("wire_strb_t2", wr2, 3'b000);
    chk("wire_hold",    reg_o_a[63:32], 32'hA5A5A5A5);
    reg_i[63:32] = 32'h00000042;
    xfer(0, 0, 2'd1, 4'hF, 32'h0, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("wire_rd_dat",  rdat, 32'h42);
    chk("wire_rd_strb", rd1, 3'b010);

    // external-ack read, rack in cycle T+4
    reg_i[95:64] = 32'h00001234;
    xfer(0, 0, 2'd2, 4'hF, 32'h0, 4, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("ext_rd_lat",   lat, 5);
    chk("ext_rd_term",  {30'b0, ack, err}, 32'h2);
    chk("ext_rd_dat",   rdat, 32'h1234);
    chk("ext_rd_stall", {31'b0, stall_all}, 32'h1);
    chk("ext_rd_strb",  rd1, 3'b100);

    // external-ack write, no response: error after 15 WAIT cycles
    xfer(0, 1, 2'd2, 4'hF, 32'hCAFEF00D, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("ext_to_lat",  lat, 17);
    chk("ext_to_term", {30'b0, ack, err}, 32'h1);
    chk("ext_to_dat",  rdat, 32'h0);
    chk("ext_wr_strb", wr1, 3'b100);
    chk("ext_wr_data", rego1[95:64], 32'hCAFEF00D);
    chk("ext_wr_hold", reg_o_a[95:64], 32'hCAFEF00D);

    // wack in the expiry cycle wins
    xfer(0, 1, 2'd2, 4'hF, 32'h0000BEEF, 16, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("ext_edge_lat",  lat, 17);
    chk("ext_edge_term", {30'b0, ack, err}, 32'h2);

    // stray acks outside an access
    wack_a = 3'b111; rack_a = 3'b111;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen |= ack_a | err_a | stall_a;
    end
    wack_a = '0; rack_a = '0;
    chk("stray_ack", {31'b0, seen}, 32'h0);

    // unmapped index: ack on A, err on B, never strobes
    xfer(0, 0, 2'd3, 4'hF, 32'h0, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("unm_a_lat",  lat, 2);
    chk("unm_a_term", {30'b0, ack, err}, 32'h2);
    chk("unm_a_dat",  rdat, 32'h0);
    chk("unm_a_strb", {23'b0, wr1, rd1, wr2}, 32'h0);
    xfer(1, 0, 2'd3, 4'hF, 32'h0, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("unm_b_rd_lat",  lat, 2);
    chk("unm_b_rd_term", {30'b0, ack, err}, 32'h1);
    chk("unm_b_rd_strb", {23'b0, wr1, rd1, wr2}, 32'h0);
    xfer(1, 1, 2'd3, 4'hF, 32'h12345678, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("unm_b_wr_term", {30'b0, ack, err}, 32'h1);
    chk("unm_b_wr_strb", {23'b0, wr1, rd1, wr2}, 32'h0);

    // read-only slot on B
    xfer(1, 1, 2'd2, 4'hF, 32'hFFFF0000, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("ro_wr_term", {30'b0, ack, err}, 32'h2);
    chk("ro_wr_strb", {29'b0, wr1 | wr2}, 32'h0);
    chk("ro_reg_o",   reg_o_b[95:64], 32'h0);
    reg_i[95:64] = 32'h5A5A0F0F;
    xfer(1, 0, 2'd2, 4'hF, 32'h0, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
    chk("ro_rd_dat", rdat, 32'h5A5A0F0F);
    chk("ro_rd_strb", rd1, 3'b100);

    // random traffic on A against a word/byte-merge model
    m_stor = 32'hDE22BE44;
    for (int i = 0; i < 40; i++) begin
      slot = 2'($urandom_range(0, 2));
      if (slot == 2'd2) slot = 2'd3;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      reg_i = {$urandom, $urandom, $urandom};
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      xfer(0, w, slot, s, d, -1, ack, err, rdat, lat, wr1, rd1, wr2, rego1, stall_all);
      chk("rnd_lat", lat, 2);
      chk("rnd_term", {30'b0, ack, err}, 32'h2);
      if (slot == 2'd0 && w) begin
        m_stor = (m_stor & ~mask) | (d & mask);
        chk("rnd_st_wr", reg_o_a[31:0], m_stor);
      end else if (slot == 2'd0) begin
        chk("rnd_st_rd", rdat, m_stor);
      end else if (slot == 2'd1 && w) begin
        chk("rnd_wire_wr", rego1[63:32], d);
      end else if (slot == 2'd1) begin
        chk("rnd_wire_rd", rdat, reg_i[63:32]);
      end else begin
        chk("rnd_unm_rd", rdat, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
